instr_fetch_mem: RTL and testbench

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

---
 rtl/instr_fetch_mem.sv | 109 ++++++++++
 tb/tb_instr_fetch_mem.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_mem.sv
// Instruction memory: NOP-fill sweep after reset, program load port, and a
// single registered fetch response slot with valid/ready backpressure.
module instr_fetch_mem #(
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       DEPTH     = 64,
    parameter int unsigned       BYTE_ADDR = 1,
    parameter logic [DATA_W-1:0] NOP_WORD  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic              rsp_fault
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Range check is done wider than both ADDR_W and DEPTH so nothing wraps into range.
    localparam int unsigned CMP_W = (ADDR_W > 13) ? ADDR_W + 1 : 14;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [CMP_W-1:0] DEPTH_C  = CMP_W'(DEPTH);

    function automatic logic [CMP_W-1:0] word_index(input logic [ADDR_W-1:0] a);
        logic [CMP_W-1:0] w;
        w = CMP_W'(a);
        if (BYTE_ADDR != 0) w = w >> 1;
        return w;
    endfunction

    function automatic logic addr_fault(input logic [ADDR_W-1:0] a);
        return ((BYTE_ADDR != 0) && a[0]) || (word_index(a) >= DEPTH_C);
    endfunction

    logic [0:0]        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_instr;
    logic              r_rsp_fault;

    logic              w_run;
    logic              w_req_fire;
    logic              w_req_fault;
    logic [CMP_W-1:0]  w_req_idx;
    logic              w_load_fire;
    logic [CMP_W-1:0]  w_load_idx;

    assign w_run       = (r_state == ST_RUN);
    assign w_req_idx   = word_index(req_addr);
    assign w_req_fault = addr_fault(req_addr);
    assign w_load_idx  = word_index(load_addr);
    assign w_load_fire = w_run && load_en && !addr_fault(load_addr);

    assign load_ready  = w_run;
    assign req_ready   = w_run && (!r_rsp_valid || rsp_ready);
    assign w_req_fire  = req_valid && req_ready;

    assign rsp_valid   = r_rsp_valid;
    assign rsp_instr   = r_rsp_instr;
    assign rsp_fault   = r_rsp_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_idx   <= '0;
        end else if (r_state == ST_INIT) begin
            r_idx <= r_idx + IDX_W'(1);
            if (r_idx == LAST_IDX) begin
                r_state <= ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_idx] <= NOP_WORD;
        end else if (w_load_fire) begin
            r_mem[w_load_idx[IDX_W-1:0]] <= load_data;
        end
    end

    // The read samples pre-edge memory, so a same-cycle load is seen only by later fetches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_instr <= NOP_WORD;
            r_rsp_fault <= 1'b0;
        end else if (w_req_fire) begin
            r_rsp_valid <= 1'b1;
            r_rsp_fault <= w_req_fault;
            r_rsp_instr <= w_req_fault ? NOP_WORD : r_mem[w_req_idx[IDX_W-1:0]];
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: directed scenarios plus random traffic
// checked against an array-based memory model.
module tb_instr_fetch_mem;

    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0;
    logic [15:0] load_addr = '0;
    logic [15:0] load_data = '0;
    logic        load_ready;
    logic        req_valid = 1'b0;
    logic [15:0] req_addr = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_instr;
    logic        rsp_fault;

    always #5 clk = ~clk;

    instr_fetch_mem #(
        .DATA_W   (16),
        .ADDR_W   (16),
        .DEPTH    (DEPTH),
        .BYTE_ADDR(1),
        .NOP_WORD (16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .load_ready(load_ready),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_fault (rsp_fault)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] model [DEPTH];
    logic [16:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit ref_fault(input logic [15:0] a);
        int unsigned ba;
        ba = a;
        return (ba % 2 != 0) || (ba / 2 >= DEPTH);
    endfunction

    function automatic logic [16:0] ref_fetch(input logic [15:0] a);
        int unsigned ba;
        ba = a;
        if (ref_fault(a)) return {1'b1, 16'h0000};
        return {1'b0, model[ba / 2]};
    endfunction

    task automatic ref_load(input logic [15:0] a, input logic [15:0] d);
        int unsigned ba;
        ba = a;
        if (!ref_fault(a)) model[ba / 2] = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
    endtask

    // One clock of stimulus; fetch expectation is taken before the load so
    // a same-cycle collision sees the old word.
    task automatic step(input logic le, input logic [15:0] la, input logic [15:0] ld,
                        input logic rv, input logic [15:0] ra, input logic rr, output bit acc);
        load_en = le; load_addr = la; load_data = ld;
        req_valid = rv; req_addr = ra; rsp_ready = rr;
        @(negedge clk);
        acc = req_valid && req_ready;
        if (acc) sb.push_back(ref_fetch(ra));
        if (load_en && load_ready) ref_load(la, ld);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1, acc);
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] d);
        bit acc;
        step(1'b1, a, d, 1'b0, 16'h0, 1'b1, acc);
    endtask

    task automatic fetch(input logic [15:0] a, output int waits);
        bit acc;
        acc = 1'b0;
        waits = 0;
        while (!acc && waits < 20) begin
            step(1'b0, 16'h0, 16'h0, 1'b1, a, 1'b1, acc);
            if (!acc) waits++;
        end
        if (!acc) chk("fetch_accept_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                chk("init_req_ready", {31'd0, req_ready}, 32'd0);
                chk("init_load_ready", {31'd0, load_ready}, 32'd0);
            end
        end
        chk("init_cycles", n, DEPTH);
    endtask

    task automatic drain();
        int n;
        bit acc;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1, acc);
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    function automatic logic [15:0] pick_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 16'($urandom);
        if (r < 3) return 16'($urandom_range(0, 16'h9F));
        return 16'($urandom_range(0, DEPTH - 1) * 2);
    endfunction

    bit          hold_prev = 1'b0;
    logic [15:0] prev_instr;
    logic        prev_fault;

    always @(negedge clk) begin
        logic [16:0] e;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
                chk("hold_instr", {16'd0, rsp_instr}, {16'd0, prev_instr});
                chk("hold_fault", {31'd0, rsp_fault}, {31'd0, prev_fault});
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("rsp_without_request", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_instr", {16'd0, rsp_instr}, {16'd0, e[15:0]});
                    chk("rsp_fault", {31'd0, rsp_fault}, {31'd0, e[16]});
                end
            end
            hold_prev  = rsp_valid && !rsp_ready;
            prev_instr = rsp_instr;
            prev_fault = rsp_fault;
        end
    end

    initial begin
        bit acc;
        int w0, w1, w2;

        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_instr", {16'd0, rsp_instr}, 32'h0);
        chk("rst_rsp_fault", {31'd0, rsp_fault}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd0);

        // Loads attempted during the sweep must be ignored.
        load_en = 1'b1; load_addr = 16'h0000; load_data = 16'hBEEF;
        rst = 1'b0;
        wait_init();
        load_en = 1'b0;

        fetch(16'h0002, w0);
        fetch(16'h0000, w0);
        idle(2);

        load(16'h0000, 16'h3111);
        load(16'h0002, 16'h3222);
        load(16'h0004, 16'h6FFC);
        fetch(16'h0000, w0);
        fetch(16'h0002, w1);
        fetch(16'h0004, w2);
        chk("b2b_waits", w0 + w1 + w2, 0);
        idle(2);

        step(1'b0, 16'h0, 16'h0, 1'b1, 16'h0000, 1'b0, acc);
        chk("bp_first_accept", {31'd0, acc}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0, 16'h0, 1'b1, 16'h0002, 1'b0, acc);
            chk("bp_req_ready", {31'd0, acc}, 32'd0);
        end
        chk("bp_instr", {16'd0, rsp_instr}, 32'h3111);
        step(1'b0, 16'h0, 16'h0, 1'b1, 16'h0002, 1'b1, acc);
        chk("bp_release_accept", {31'd0, acc}, 32'd1);
        idle(2);

        fetch(16'h0003, w0);
        fetch(16'h0080, w0);
        fetch(16'h0100, w0);
        fetch(16'hFFFE, w0);
        load(16'h0080, 16'h5555);
        load(16'h0001, 16'h7777);
        load(16'h0100, 16'h9999);
        fetch(16'h0000, w0);
        fetch(16'h0080, w0);
        idle(2);

        step(1'b1, 16'h0002, 16'hAAAA, 1'b1, 16'h0002, 1'b1, acc);
        chk("collide_accept", {31'd0, acc}, 32'd1);
        fetch(16'h0002, w0);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, pick_addr(), 16'($urandom),
                 $urandom_range(0, 2) != 0, pick_addr(), $urandom_range(0, 3) != 0, acc);
        end
        drain();

        step(1'b0, 16'h0, 16'h0, 1'b1, 16'h0004, 1'b0, acc);
        chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_rsp_instr", {16'd0, rsp_instr}, 32'h0);
        chk("midrst_rsp_fault", {31'd0, rsp_fault}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("midrst_load_ready", {31'd0, load_ready}, 32'd0);
        sb.delete();
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_init();
        fetch(16'h0000, w0);
        fetch(16'h0002, w0);
        fetch(16'h0004, w0);
        drain();
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
